// File: rtl/spi_job_arbiter_pkg.sv
// spi_job_arbiter_pkg: shared widths, FSM encoding and defaults
// for the two-requester SPI job arbiter.
package spi_job_arbiter_pkg;

  localparam int DEF_MEMORY_ADDR_WIDTH = 9;
  localparam int DEF_RESERVED_DATA_LEN = 8;
  localparam int DIV_W = 8;

  localparam logic [15:0] DEF_TIMEOUT_CYC = 16'd4096;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_LOAD  = 2'b01,
    ST_RUN   = 2'b11,
    ST_FLUSH = 2'b10
  } arb_state_e;

endpackage

// File: rtl/spi_job_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin grant, one-hot or zero.
// On a tie the requester that is not 'last' wins.
module rr_arb2
  import spi_job_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = req;
    if (&req) gnt = last ? 2'b01 : 2'b10;
  end

endmodule

// File: rtl/spi_job_arbiter.sv
// spi_job_arbiter: shares one SPI serializer between two requesters.
// Optional watchdog abort enabled by defining SPI_ARB_TIMEOUT_EN.
module spi_job_arbiter
  import spi_job_arbiter_pkg::*;
#(
  parameter int          MEMORY_ADDR_WIDTH = DEF_MEMORY_ADDR_WIDTH,
  parameter int          RESERVED_DATA_LEN = DEF_RESERVED_DATA_LEN,
  parameter logic [15:0] TIMEOUT_CYC       = DEF_TIMEOUT_CYC
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         REQ0,
  input  logic                         REQ1,
  input  logic [MEMORY_ADDR_WIDTH-1:0] ADDR0,
  input  logic [MEMORY_ADDR_WIDTH-1:0] ADDR1,
  input  logic [RESERVED_DATA_LEN-1:0] LEN0,
  input  logic [RESERVED_DATA_LEN-1:0] LEN1,
  input  logic [DIV_W-1:0]             DIV0,
  input  logic [DIV_W-1:0]             DIV1,
  output logic                         GNT0,
  output logic                         GNT1,
  output logic                         DONE0,
  output logic                         DONE1,
  output logic                         ERR0,
  output logic                         ERR1,
  output logic                         BGN,
  output logic [MEMORY_ADDR_WIDTH-1:0] ADDR_BGN,
  output logic [RESERVED_DATA_LEN-1:0] DATA_LEN,
  output logic [DIV_W-1:0]             FREQ_DIV,
  input  logic                         SPI_DONE,
  output logic                         BUSY,
  output logic                         OWNER
);

  arb_state_e state_q, state_d;
  logic [1:0] gnt;
  logic       timeout;
  logic       idle;
  logic       flush;
  logic       take;

  rr_arb2 u_rr (
    .req  ({REQ1, REQ0}),
    .last (OWNER),
    .gnt  (gnt)
  );

  assign idle  = (state_q == ST_IDLE);
  assign flush = (state_q == ST_FLUSH);
  assign take  = idle && (|gnt);

`ifdef SPI_ARB_TIMEOUT_EN
  logic [15:0] cnt_q;
  logic        err_q;

  assign timeout = (state_q == ST_RUN) && !SPI_DONE &&
                   (cnt_q == TIMEOUT_CYC - 16'd1);

  // err_q keeps the outcome of the last RUN cycle for FLUSH
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (state_q == ST_LOAD) cnt_q <= '0;
      else if (state_q == ST_RUN) cnt_q <= cnt_q + 16'd1;
      if (state_q == ST_RUN) err_q <= timeout;
    end
  end

  assign ERR0 = !RST && flush && err_q && !OWNER;
  assign ERR1 = !RST && flush && err_q && OWNER;
`else
  logic unused_cfg;
  assign unused_cfg = ^TIMEOUT_CYC;
  assign timeout    = 1'b0;
  assign ERR0       = 1'b0;
  assign ERR1       = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (|gnt) state_d = ST_LOAD;
      ST_LOAD:  state_d = ST_RUN;
      ST_RUN:   if (SPI_DONE || timeout) state_d = ST_FLUSH;
      ST_FLUSH: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= ST_IDLE;
      OWNER    <= 1'b1;
      ADDR_BGN <= '0;
      DATA_LEN <= '0;
      FREQ_DIV <= '0;
    end else begin
      state_q <= state_d;
      if (take) begin
        OWNER    <= gnt[1];
        ADDR_BGN <= gnt[1] ? ADDR1 : ADDR0;
        DATA_LEN <= gnt[1] ? LEN1  : LEN0;
        FREQ_DIV <= gnt[1] ? DIV1  : DIV0;
      end
    end
  end

  assign GNT0  = !RST && take && gnt[0];
  assign GNT1  = !RST && take && gnt[1];
  assign DONE0 = !RST && flush && !OWNER;
  assign DONE1 = !RST && flush && OWNER;
  assign BGN   = (state_q == ST_RUN);
  assign BUSY  = !idle;

endmodule

// File: tb/tb_spi_job_arbiter.sv
// tb_spi_job_arbiter: directed self-checking bench for spi_job_arbiter.
// Timeout scenarios run when SPI_ARB_TIMEOUT_EN is defined.
module tb_spi_job_arbiter;
  import spi_job_arbiter_pkg::*;

  logic       CLK = 1'b0;
  logic       RST;
  logic       REQ0, REQ1;
  logic [8:0] ADDR0, ADDR1;
  logic [7:0] LEN0, LEN1, DIV0, DIV1;
  logic       GNT0, GNT1, DONE0, DONE1, ERR0, ERR1;
  logic       BGN, BUSY, OWNER, SPI_DONE;
  logic [8:0] ADDR_BGN;
  logic [7:0] DATA_LEN, FREQ_DIV;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  spi_job_arbiter #(
    .MEMORY_ADDR_WIDTH (9),
    .RESERVED_DATA_LEN (8),
    .TIMEOUT_CYC       (16'd100)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .REQ0     (REQ0),
    .REQ1     (REQ1),
    .ADDR0    (ADDR0),
    .ADDR1    (ADDR1),
    .LEN0     (LEN0),
    .LEN1     (LEN1),
    .DIV0     (DIV0),
    .DIV1     (DIV1),
    .GNT0     (GNT0),
    .GNT1     (GNT1),
    .DONE0    (DONE0),
    .DONE1    (DONE1),
    .ERR0     (ERR0),
    .ERR1     (ERR1),
    .BGN      (BGN),
    .ADDR_BGN (ADDR_BGN),
    .DATA_LEN (DATA_LEN),
    .FREQ_DIV (FREQ_DIV),
    .SPI_DONE (SPI_DONE),
    .BUSY     (BUSY),
    .OWNER    (OWNER)
  );

  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic idle_inputs();
    REQ0 = 0; REQ1 = 0; SPI_DONE = 0;
    ADDR0 = 9'h010; ADDR1 = 9'h123;
    LEN0 = 8'd3; LEN1 = 8'd7;
    DIV0 = 8'd4; DIV1 = 8'd9;
  endtask

  task automatic do_reset();
    idle_inputs();
    RST = 1;
    tick();
    tick();
    RST = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    RST = 1;
    tick();
    tick();
    #1;
    checks++;
    if ({BGN, BUSY} !== 2'b00) begin
      errors++;
      $display("FAIL reset_bgn_busy got %b exp 00", {BGN, BUSY});
    end
    checks++;
    if ({GNT1, GNT0, DONE1, DONE0, ERR1, ERR0} !== 6'b0) begin
      errors++;
      $display("FAIL reset_pulses got %b exp 000000",
               {GNT1, GNT0, DONE1, DONE0, ERR1, ERR0});
    end
    checks++;
    if ({ADDR_BGN, DATA_LEN, FREQ_DIV} !== 25'b0) begin
      errors++;
      $display("FAIL reset_latches got %h %h %h exp 0",
               ADDR_BGN, DATA_LEN, FREQ_DIV);
    end
    checks++;
    if (OWNER !== 1'b1) begin
      errors++;
      $display("FAIL reset_owner got %b exp 1", OWNER);
    end
  endtask

  task automatic test_single();
    int bad;
    do_reset();
    REQ0 = 1; ADDR0 = 9'h010; LEN0 = 8'd3; DIV0 = 8'd4;
    #1;
    checks++;
    if ({GNT1, GNT0} !== 2'b01) begin
      errors++;
      $display("FAIL single_gnt got %b exp 01", {GNT1, GNT0});
    end
    tick();
    REQ0 = 0;
    #1;
    checks++;
    if ({BGN, BUSY, OWNER} !== 3'b010) begin
      errors++;
      $display("FAIL single_load got %b exp 010", {BGN, BUSY, OWNER});
    end
    checks++;
    if ({ADDR_BGN, DATA_LEN, FREQ_DIV} !== {9'h010, 8'd3, 8'd4}) begin
      errors++;
      $display("FAIL single_params got %h %h %h exp 010 03 04",
               ADDR_BGN, DATA_LEN, FREQ_DIV);
    end
    bad = 0;
    for (int c = 2; c <= 50; c++) begin
      tick();
      if (c == 50) SPI_DONE = 1;
      if (BGN !== 1'b1 || DONE0 !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL single_run got %0d bad cycles exp 0", bad);
    end
    tick();
    SPI_DONE = 0;
    #1;
    checks++;
    if ({DONE1, DONE0, BGN, ERR0} !== 4'b0100) begin
      errors++;
      $display("FAIL single_done got %b exp 0100",
               {DONE1, DONE0, BGN, ERR0});
    end
    tick();
    checks++;
    if ({DONE0, BUSY} !== 2'b00) begin
      errors++;
      $display("FAIL single_idle got %b exp 00", {DONE0, BUSY});
    end
  endtask

  task automatic test_param_stability();
    int bad;
    do_reset();
    REQ0 = 1; ADDR0 = 9'h0AA; LEN0 = 8'd0; DIV0 = 8'd0;
    tick();
    REQ0 = 0; SPI_DONE = 1;
    ADDR0 = 9'h1FF; LEN0 = 8'hFF; DIV0 = 8'hFF;
    tick();
    SPI_DONE = 0;
    checks++;
    if (BGN !== 1'b1) begin
      errors++;
      $display("FAIL stab_load_ignores_done got %b exp 1", BGN);
    end
    checks++;
    if ({ADDR_BGN, DATA_LEN, FREQ_DIV} !== {9'h0AA, 8'd0, 8'd0}) begin
      errors++;
      $display("FAIL stab_zero_params got %h %h %h exp 0aa 00 00",
               ADDR_BGN, DATA_LEN, FREQ_DIV);
    end
    bad = 0;
    for (int c = 3; c <= 10; c++) begin
      tick();
      if (c == 10) SPI_DONE = 1;
      if (ADDR_BGN !== 9'h0AA || BGN !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL stab_run got %0d bad cycles exp 0", bad);
    end
    tick();
    checks++;
    if ({ADDR_BGN, DONE0} !== {9'h0AA, 1'b1}) begin
      errors++;
      $display("FAIL stab_flush got %h %b exp 0aa 1", ADDR_BGN, DONE0);
    end
    tick();
    checks++;
    if ({BUSY, DONE0} !== 2'b00) begin
      errors++;
      $display("FAIL stab_flush_ignores_done got %b exp 00", {BUSY, DONE0});
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_tie();
    logic [1:0] exp;
    logic [8:0] ea;
    do_reset();
    REQ0 = 1; REQ1 = 1;
    for (int j = 0; j < 4; j++) begin
      exp = (j % 2 == 1) ? 2'b10 : 2'b01;
      ea  = (j % 2 == 1) ? 9'h123 : 9'h010;
      #1;
      checks++;
      if ({GNT1, GNT0, BGN} !== {exp, 1'b0}) begin
        errors++;
        $display("FAIL tie_gnt job %0d got %b exp %b",
                 j, {GNT1, GNT0, BGN}, {exp, 1'b0});
      end
      tick();
      #1;
      checks++;
      if ({ADDR_BGN, GNT1, GNT0} !== {ea, 2'b00}) begin
        errors++;
        $display("FAIL tie_load job %0d got %h %b exp %h 00",
                 j, ADDR_BGN, {GNT1, GNT0}, ea);
      end
      tick();
      SPI_DONE = 1;
      tick();
      SPI_DONE = 0;
      #1;
      checks++;
      if ({DONE1, DONE0, GNT1, GNT0} !== {exp, 2'b00}) begin
        errors++;
        $display("FAIL tie_done job %0d got %b exp %b",
                 j, {DONE1, DONE0, GNT1, GNT0}, {exp, 2'b00});
      end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    do_reset();
    REQ0 = 1;
    tick();
    REQ0 = 0;
    for (int c = 2; c <= 12; c++) tick();
    RST = 1;
    #1;
    checks++;
    if ({DONE1, DONE0} !== 2'b00) begin
      errors++;
      $display("FAIL midrst_nodone got %b exp 00", {DONE1, DONE0});
    end
    tick();
    checks++;
    if ({BGN, BUSY, DONE1, DONE0, OWNER} !== 5'b00001) begin
      errors++;
      $display("FAIL midrst_after got %b exp 00001",
               {BGN, BUSY, DONE1, DONE0, OWNER});
    end
    RST = 0;
    REQ0 = 1; REQ1 = 1;
    #1;
    checks++;
    if ({GNT1, GNT0} !== 2'b01) begin
      errors++;
      $display("FAIL midrst_tie got %b exp 01", {GNT1, GNT0});
    end
    tick();
    REQ0 = 0; REQ1 = 0;
    tick();
    SPI_DONE = 1;
    tick();
    SPI_DONE = 0;
    checks++;
    if ({DONE1, DONE0} !== 2'b01) begin
      errors++;
      $display("FAIL midrst_job_done got %b exp 01", {DONE1, DONE0});
    end
    tick();
  endtask

`ifdef SPI_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int bad;
    do_reset();
    REQ1 = 1;
    #1;
    checks++;
    if ({GNT1, GNT0} !== 2'b10) begin
      errors++;
      $display("FAIL to_gnt got %b exp 10", {GNT1, GNT0});
    end
    tick();
    REQ1 = 0;
    bad = 0;
    for (int c = 2; c <= 101; c++) begin
      tick();
      if (BGN !== 1'b1 || DONE1 !== 1'b0 || ERR1 !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL to_run got %0d bad cycles exp 0", bad);
    end
    tick();
    checks++;
    if ({DONE1, ERR1, DONE0, ERR0, BGN} !== 5'b11000) begin
      errors++;
      $display("FAIL to_abort got %b exp 11000",
               {DONE1, ERR1, DONE0, ERR0, BGN});
    end
    tick();
    REQ1 = 1;
    tick();
    REQ1 = 0;
    for (int c = 2; c <= 101; c++) begin
      tick();
      if (c == 101) SPI_DONE = 1;
    end
    tick();
    SPI_DONE = 0;
    checks++;
    if ({DONE1, ERR1} !== 2'b10) begin
      errors++;
      $display("FAIL to_limit_done got %b exp 10", {DONE1, ERR1});
    end
    tick();
  endtask
`else
  task automatic test_no_timeout();
    int bad;
    do_reset();
    REQ1 = 1;
    tick();
    REQ1 = 0;
    bad = 0;
    for (int c = 0; c < 10000; c++) begin
      tick();
      if ({BGN, ERR0, ERR1, DONE0, DONE1} !== 5'b10000) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL nto_wait got %0d bad cycles exp 0", bad);
    end
    SPI_DONE = 1;
    tick();
    SPI_DONE = 0;
    checks++;
    if ({DONE1, ERR1} !== 2'b10) begin
      errors++;
      $display("FAIL nto_done got %b exp 10", {DONE1, ERR1});
    end
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_param_stability();
    test_tie();
    test_reset_mid();
`ifdef SPI_ARB_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
